// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: load/store port between the datapath and the data-memory responder
interface data_mem_responder_if;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Stall;
  logic        AddrErr;
  modport master (output MemRead, MemWrite, Addr, WriteData, input ReadData, Stall, AddrErr);
  modport slave (input MemRead, MemWrite, Addr, WriteData, output ReadData, Stall, AddrErr);
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: fixed-latency word-addressed data RAM behind the core's load/store port
module data_mem_responder #(
  parameter int    DEPTH     = 256,
  parameter int    LATENCY   = 2,
  parameter string INIT_FILE = ""
) (
  input logic                 clk,
  input logic                 reset,
  data_mem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY + 1);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rd_q, rd_d, err_q, err_d, aerr_q, aerr_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0]   wdata_q, wdata_d, rdata_q, rdata_d;
  logic [31:0]   mem [DEPTH];
  logic          req, enter_done;
  assign req = bus.MemRead | bus.MemWrite;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    err_d   = err_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    aerr_d  = 1'b0;
    unique case (state_q)
      IDLE: if (req) begin
        rd_d    = bus.MemRead;
        err_d   = bus.Addr[1:0] != 2'b0 || bus.Addr[31:AW+2] != '0 || (bus.MemRead && bus.MemWrite);
        idx_d   = bus.Addr[AW+1:2];
        wdata_d = bus.WriteData;
        cnt_d   = CW'(LATENCY - 1);
        state_d = (LATENCY == 1) ? DONE : WAIT;
      end
      WAIT: begin
        cnt_d   = cnt_q - 1'b1;
        state_d = (cnt_q <= CW'(1)) ? DONE : WAIT;
      end
      default: state_d = IDLE;
    endcase
    // The _d copies equal the captured request on both the WAIT and the LATENCY=1 path
    enter_done = state_d == DONE && state_q != DONE;
    if (enter_done) begin
      rdata_d = err_d ? 32'h0 : rd_d ? mem[idx_d] : rdata_q;
      aerr_d  = err_d;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      err_q   <= 1'b0;
      aerr_q  <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
      aerr_q  <= aerr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  always_ff @(posedge clk)
    if (!reset && enter_done && !err_d && !rd_d) mem[idx_d] <= wdata_d;
  assign bus.Stall    = !reset && ((state_q == IDLE && req) || state_q == WAIT);
  assign bus.ReadData = rdata_q;
  assign bus.AddrErr  = aerr_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: scoreboard bench for LATENCY=2 and LATENCY=1 builds sharing one stimulus port
module tb_data_mem_responder;
  logic clk = 1'b0, reset = 1'b1, sel = 1'b0;
  logic mem_read = 1'b0, mem_write = 1'b0;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  int cyc = 0, n_chk = 0, n_fail = 0;
  typedef struct {logic chk_rd; logic [31:0] rdata; logic err; int stall;} exp_t;
  exp_t sb[$];
  logic [31:0] model [int];
  data_mem_responder_if bus_a ();
  data_mem_responder_if bus_b ();
  assign bus_a.MemRead = mem_read;
  assign bus_a.MemWrite = mem_write;
  assign bus_a.Addr = addr;
  assign bus_a.WriteData = wdata;
  assign bus_b.MemRead = mem_read;
  assign bus_b.MemWrite = mem_write;
  assign bus_b.Addr = addr;
  assign bus_b.WriteData = wdata;
  data_mem_responder #(.DEPTH(256), .LATENCY(2)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  data_mem_responder #(.DEPTH(256), .LATENCY(1)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));
  wire        stall_o = sel ? bus_b.Stall : bus_a.Stall;
  wire [31:0] rdata_o = sel ? bus_b.ReadData : bus_a.ReadData;
  wire        aerr_o  = sel ? bus_b.AddrErr : bus_a.AddrErr;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic expect_access(input logic r, w, input logic [31:0] a, d, input int lat);
    exp_t e;
    e.err    = a[1:0] != 2'b0 || a >= 32'h400 || (r && w);
    e.stall  = lat;
    e.chk_rd = r || e.err;
    e.rdata  = (e.err || !r) ? 32'h0 : model[int'(a >> 2)];
    if (!e.err && w) model[int'(a >> 2)] = d;
    sb.push_back(e);
  endtask

  task automatic access(input logic r, w, input logic [31:0] a, d, input logic chg,
                        input logic [31:0] ca, output int st, output logic [31:0] q,
                        output logic ae, output logic to);
    bit fin = 0;
    mem_read = r; mem_write = w; addr = a; wdata = d; st = 0;
    for (int i = 0; i < 20 && !fin; i++) begin
      @(negedge clk);
      if (!stall_o) fin = 1;
      else begin
        st++;
        if (chg && st == 1) begin @(posedge clk); #1 addr = ca; end
      end
    end
    q = rdata_o; ae = aerr_o; to = !fin;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    n_chk++; if (bus_a.ReadData !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", bus_a.ReadData); end
    n_chk++; if (bus_a.AddrErr !== 1'b0) begin n_fail++; $display("FAIL reset_aerr: got %b expected 0", bus_a.AddrErr); end
    n_chk++; if (bus_a.Stall !== 1'b0 || bus_b.Stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b/%b expected 0/0", bus_a.Stall, bus_b.Stall); end
    @(posedge clk); #1;
  endtask

  // Table-driven single accesses with an idle cycle after each, checking the AddrErr pulse width
  task automatic test_accesses(input string nm);
    logic        rs [8] = '{0, 1, 0, 1, 1, 1, 0, 1};
    logic        ws [8] = '{1, 0, 1, 0, 0, 0, 1, 0};
    logic [31:0] as [8] = '{32'h10, 32'h10, 32'h3FC, 32'h3FC, 32'h12, 32'h400, 32'h10, 32'h10};
    logic [31:0] ds [8] = '{32'hDEADBEEF, 0, 32'hA5A5A5A5, 0, 0, 0, 32'hBAD, 0};
    int st; logic [31:0] q; logic ae, to; exp_t e;
    for (int i = 0; i < 8; i++) begin
      if (i == 6) begin expect_access(1, 1, as[i], ds[i], 2); access(1, 1, as[i], ds[i], 0, 0, st, q, ae, to); end
      else begin expect_access(rs[i], ws[i], as[i], ds[i], 2); access(rs[i], ws[i], as[i], ds[i], 0, 0, st, q, ae, to); end
      idle();
      e = sb.pop_front();
      n_chk++; if (to || st !== e.stall) begin n_fail++; $display("FAIL %s_stall[%0d]: got %0d timeout=%b expected %0d", nm, i, st, to, e.stall); end
      n_chk++; if (ae !== e.err) begin n_fail++; $display("FAIL %s_aerr[%0d]: got %b expected %b", nm, i, ae, e.err); end
      if (e.chk_rd) begin n_chk++; if (q !== e.rdata) begin n_fail++; $display("FAIL %s_rdata[%0d]: got %h expected %h", nm, i, q, e.rdata); end end
      @(negedge clk);
      n_chk++; if (aerr_o !== 1'b0) begin n_fail++; $display("FAIL %s_aerr_pulse[%0d]: got %b expected 0", nm, i, aerr_o); end
      if (i == 1) begin
        repeat (2) @(negedge clk);
        n_chk++; if (rdata_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL %s_rdata_hold: got %h expected deadbeef", nm, rdata_o); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    int st, c0; logic [31:0] q; logic ae, to; exp_t e;
    c0 = cyc;
    expect_access(0, 1, 32'h0, 32'h1, 2);
    access(0, 1, 32'h0, 32'h1, 0, 0, st, q, ae, to);
    e = sb.pop_front();
    n_chk++; if (to || st !== e.stall) begin n_fail++; $display("FAIL b2b_sw_stall: got %0d expected %0d", st, e.stall); end
    expect_access(1, 0, 32'h0, 32'h0, 2);
    access(1, 0, 32'h0, 32'h0, 0, 0, st, q, ae, to);
    idle();
    e = sb.pop_front();
    n_chk++; if (to || st !== e.stall) begin n_fail++; $display("FAIL b2b_lw_stall: got %0d expected %0d", st, e.stall); end
    n_chk++; if (q !== e.rdata) begin n_fail++; $display("FAIL b2b_lw_rdata: got %h expected %h", q, e.rdata); end
    n_chk++; if (cyc - c0 !== 6) begin n_fail++; $display("FAIL b2b_cycles: got %0d expected 6", cyc - c0); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_wait();
    int st; logic [31:0] q; logic ae, to; exp_t e;
    expect_access(0, 1, 32'h8, 32'h12345678, 2);
    access(0, 1, 32'h8, 32'h12345678, 0, 0, st, q, ae, to);
    idle();
    void'(sb.pop_front());
    @(posedge clk); #1;
    mem_write = 1'b1; addr = 32'h8; wdata = 32'h55;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk) reset = 1'b1;
    #1;
    n_chk++; if (bus_a.Stall !== 1'b0) begin n_fail++; $display("FAIL rst_wait_stall: got %b expected 0", bus_a.Stall); end
    n_chk++; if (bus_a.ReadData !== 32'h0) begin n_fail++; $display("FAIL rst_wait_rdata: got %h expected 0", bus_a.ReadData); end
    @(posedge clk); #1;
    idle();
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    expect_access(1, 0, 32'h8, 32'h0, 2);
    access(1, 0, 32'h8, 32'h0, 0, 0, st, q, ae, to);
    idle();
    e = sb.pop_front();
    n_chk++; if (to || q !== e.rdata) begin n_fail++; $display("FAIL rst_wait_old: got %h expected %h", q, e.rdata); end
    @(posedge clk); #1;
  endtask

  // Address changed after capture: in WAIT for LATENCY=2, in DONE for LATENCY=1
  task automatic test_addr_change(input logic b, input int lat);
    logic        rs [3] = '{0, 1, 1};
    logic [31:0] as [3] = '{32'h24, 32'h24, 32'h10};
    logic [31:0] ds [3] = '{32'hCAFEF00D, 0, 0};
    int st; logic [31:0] q; logic ae, to; exp_t e;
    sel = b;
    for (int i = 0; i < 3; i++) begin
      expect_access(rs[i], !rs[i], as[i] + (b ? 32'h4 : 32'h0), ds[i] + 32'(lat), lat);
      access(rs[i], !rs[i], as[i] + (b ? 32'h4 : 32'h0), ds[i] + 32'(lat), 1, 32'h20, st, q, ae, to);
      idle();
      e = sb.pop_front();
      n_chk++; if (to || st !== e.stall) begin n_fail++; $display("FAIL chg_l%0d_stall[%0d]: got %0d expected %0d", lat, i, st, e.stall); end
      n_chk++; if (ae !== e.err) begin n_fail++; $display("FAIL chg_l%0d_aerr[%0d]: got %b expected %b", lat, i, ae, e.err); end
      if (e.chk_rd) begin n_chk++; if (q !== e.rdata) begin n_fail++; $display("FAIL chg_l%0d_rdata[%0d]: got %h expected %h", lat, i, q, e.rdata); end end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_accesses("acc");
    test_back_to_back();
    test_reset_mid_wait();
    test_addr_change(0, 2);
    test_addr_change(1, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
